csa_pipe_adder: RTL



---
 rtl/csa_pipe_adder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder
//   Pipelined multi-operand adder. NUM_OPS operands of WIDTH bits are
//   registered (S1), reduced by a carry-save tree of 3:2 compressors to a
//   sum/carry pair (S2), and resolved by a carry-propagate add (S3).
//   Fixed 3-cycle latency with a whole-pipeline stall on backpressure.
//
//   Build option: define CSA_SIGNED_EN for two's-complement operands
//   (sign extension in S1); undefined gives unsigned operands.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand bundle valid
//   in_ready   bundle accepted this cycle (combinational from out_ready/v3)
//   in_data    operand i at bits [i*WIDTH +: WIDTH]
//   out_valid  out_sum valid
//   out_ready  consumer accepts the result
//   out_sum    sum of all operands, WIDTH+$clog2(NUM_OPS) bits

module csa_pipe_adder #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]            in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH+$clog2(NUM_OPS)-1:0]    out_sum
);

  localparam int OUT_W = WIDTH + $clog2(NUM_OPS);

  // Vector count after one 3:2 level: each full group of 3 becomes 2,
  // leftovers pass straight through.
  function automatic int next_cnt(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int cnt_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = next_cnt(n);
    return n;
  endfunction

  function automatic int num_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_cnt(n);
      l++;
    end
    return l;
  endfunction

  localparam int NUM_LVL = num_levels(NUM_OPS);

  logic             w_adv;
  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic [OUT_W-1:0] w_ext   [NUM_OPS];
  logic [OUT_W-1:0] r_s1_op [NUM_OPS];
  logic [OUT_W-1:0] w_tree  [NUM_LVL+1][NUM_OPS];
  logic [OUT_W-1:0] r_s2_sum;
  logic [OUT_W-1:0] r_s2_carry;
  logic [OUT_W-1:0] r_out_sum;

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign out_sum   = r_out_sum;

  // Operand extension to the result width.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_ext
`ifdef CSA_SIGNED_EN
    assign w_ext[i] = {{(OUT_W-WIDTH){in_data[i*WIDTH+WIDTH-1]}}, in_data[i*WIDTH +: WIDTH]};
`else
    assign w_ext[i] = {{(OUT_W-WIDTH){1'b0}}, in_data[i*WIDTH +: WIDTH]};
`endif
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lvl0
    assign w_tree[0][i] = r_s1_op[i];
  end

  // Carry-save reduction. Level l holds cnt_at(l) live vectors in the low
  // slots; unused high slots are tied to zero. Carries are shifted left and
  // the bit falling off the top is dropped, which is harmless because the
  // whole sum is computed modulo 2^OUT_W and never overflows it.
  for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
    localparam int N = cnt_at(NUM_OPS, l);
    localparam int G = N / 3;
    localparam int R = N - 3 * G;

    for (genvar g = 0; g < G; g++) begin : g_fa
      logic [OUT_W-1:0] w_a;
      logic [OUT_W-1:0] w_b;
      logic [OUT_W-1:0] w_c;
      assign w_a = w_tree[l][3*g];
      assign w_b = w_tree[l][3*g+1];
      assign w_c = w_tree[l][3*g+2];
      assign w_tree[l+1][2*g]   = w_a ^ w_b ^ w_c;
      assign w_tree[l+1][2*g+1] = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign w_tree[l+1][2*G+r] = w_tree[l][3*G+r];
    end

    for (genvar z = 2*G+R; z < NUM_OPS; z++) begin : g_zero
      assign w_tree[l+1][z] = '0;
    end
  end

  // Data registers only capture when their stage receives a valid item,
  // so out_sum keeps the last result across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) r_s1_op[i] <= '0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_out_sum  <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        for (int i = 0; i < NUM_OPS; i++) r_s1_op[i] <= w_ext[i];
      end
      if (r_v1) begin
        r_s2_sum   <= w_tree[NUM_LVL][0];
        r_s2_carry <= w_tree[NUM_LVL][1];
      end
      if (r_v2) begin
        r_out_sum <= r_s2_sum + r_s2_carry;
      end
    end
  end

endmodule
